// File: rtl/strobe_timer_arbiter_pkg.sv
// Shared types and constants for the strobe timer arbiter.
package strobe_timer_arbiter_pkg;

  // Sequencer states; 3-bit encoding shared by the top and any observers.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    WAIT_RDY = 3'd2,
    RUN      = 3'd3,
    DONE     = 3'd4
  } state_e;

  // Periods below this cannot produce a meaningful strobe and are rejected.
  localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/strobe_timer_arbiter_if.sv
// Client-facing bundle of the strobe timer arbiter: requests, periods, tick in;
// grant/done/status out.
interface strobe_timer_arbiter_if #(
  parameter int REQUESTERS = 4,
  parameter int WIDTH      = 32
);
  logic                          tick;
  logic [REQUESTERS-1:0]         req;
  logic [REQUESTERS*WIDTH-1:0]   req_period;
  logic [REQUESTERS-1:0]         grant;
  logic [REQUESTERS-1:0]         done;
  logic                          error;
  logic                          tick_overrun;
  logic                          busy;

  // Clients drive requests and ticks.
  modport master (
    output tick, req, req_period,
    input  grant, done, error, tick_overrun, busy
  );

  // The arbiter consumes requests and reports ownership and completion.
  modport slave (
    input  tick, req, req_period,
    output grant, done, error, tick_overrun, busy
  );
endinterface

// File: rtl/strobe_timer_arbiter_counter.sv
// Shared one-shot counter: counts enables up to reset_value and strobes once.
// After reset and after every enable it is unavailable (ready=0) for
// CHUNK_COUNT+1 cycles while the wide count settles.
module counter_with_strobe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] reset_value,
  output logic             ready,
  output logic             strobe
);
  localparam int CHUNK_COUNT = (LATENCY < 1) ? 1 : LATENCY;
  localparam int SETTLE      = CHUNK_COUNT + 1;
  localparam int SW          = $clog2(SETTLE + 1);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count_inc;
  logic [SW-1:0]    settle_cnt;

  assign count_inc = count + 1'b1;

  // Count enables, strobe one cycle after the enable that reaches the limit,
  // and hold ready low while the count settles.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register reading the
    // pre-edge values of its neighbours, which is what the hardware does.
    if (rst) begin
      count      <= '0;
      limit      <= reset_value;
      settle_cnt <= SW'(SETTLE);
      ready      <= 1'b0;
      strobe     <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (enable && ready) begin
        settle_cnt <= SW'(SETTLE);
        ready      <= 1'b0;
        if (count_inc == limit) begin
          strobe <= 1'b1;
          count  <= '0;
        end else begin
          count <= count_inc;
        end
      end else if (settle_cnt != '0) begin
        settle_cnt <= settle_cnt - 1'b1;
        ready      <= (settle_cnt == SW'(1));
      end
    end
  end
endmodule

// File: rtl/strobe_timer_arbiter.sv
// Round-robin arbiter that time-shares one counter_with_strobe among
// REQUESTERS one-shot timer clients. REQUESTERS must be at least 2.
module strobe_timer_arbiter
  import strobe_timer_arbiter_pkg::*;
#(
  parameter int REQUESTERS = 4,
  parameter int WIDTH      = 32,
  parameter int LATENCY    = 1
) (
  input logic                   clk,
  input logic                   rst,
  strobe_timer_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(REQUESTERS);

  state_e                state;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      own;
  logic [WIDTH-1:0]      period_q;
  logic                  pend;
  logic [REQUESTERS-1:0] grant_q;
  logic [REQUESTERS-1:0] done_q;
  logic                  error_q;
  logic                  overrun_q;

  logic                  cnt_ready;
  logic                  cnt_strobe;
  logic                  cnt_enable;
  logic                  cnt_rst;
  logic                  load_rst;
  logic                  abort_rst;
  logic                  abort;
  logic [IDX_W:0]        pick;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W-1:0]      pick_next;

  // First requester at or after 'start', wrapping; MSB flags that one exists.
  function automatic logic [IDX_W:0] rr_pick(input logic [REQUESTERS-1:0] r,
                                             input logic [IDX_W-1:0]      start);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               k;
    // NOTE: every local gets a value before any conditional write, so the
    // combinational logic using this function never needs to hold state.
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      k = (int'(start) + i) % REQUESTERS;
      if (!found && r[k]) begin
        found = 1'b1;
        idx   = IDX_W'(k);
      end
    end
    return {found, idx};
  endfunction

  assign pick      = rr_pick(bus.req, ptr);
  assign pick_idx  = pick[IDX_W-1:0];
  assign pick_next = IDX_W'((int'(pick_idx) + 1) % REQUESTERS);

  // The owner dropping its request cancels the job in any counter-owning state.
  assign abort     = (state inside {LOAD, WAIT_RDY, RUN}) && !bus.req[own];
  assign abort_rst = abort;
  assign load_rst  = (state == LOAD) && (period_q >= WIDTH'(MIN_PERIOD));
  assign cnt_rst   = rst | load_rst | abort_rst;

  // Counter enables only inside the ready window, fed by a new or pending tick.
  assign cnt_enable = (state == RUN) && !abort && (bus.tick || pend) && cnt_ready;

  // Sequencer: grant, load, wait for the counter, count ticks, complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      own       <= '0;
      grant_q   <= '0;
      pend      <= 1'b0;
      period_q  <= '0;
      done_q    <= '0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q    <= '0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick[IDX_W]) begin
            own      <= pick_idx;
            grant_q  <= REQUESTERS'(1) << pick_idx;
            period_q <= bus.req_period[pick_idx*WIDTH +: WIDTH];
            ptr      <= pick_next;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            grant_q <= '0;
            state   <= IDLE;
          end else if (period_q < WIDTH'(MIN_PERIOD)) begin
            done_q  <= grant_q;
            error_q <= 1'b1;
            grant_q <= '0;
            state   <= IDLE;
          end else begin
            state <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (abort) begin
            grant_q <= '0;
            state   <= IDLE;
          end else if (cnt_ready) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            grant_q <= '0;
            pend    <= 1'b0;
            state   <= IDLE;
          end else begin
            overrun_q <= bus.tick && pend && !cnt_enable;
            if (cnt_strobe) begin
              done_q  <= grant_q;
              grant_q <= '0;
              pend    <= 1'b0;
              state   <= DONE;
            end else if (cnt_enable) begin
              pend <= bus.tick && pend;
            end else begin
              pend <= pend || bus.tick;
            end
          end
        end
        DONE: begin
          pend  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant        = grant_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.tick_overrun = overrun_q;
  assign bus.busy         = (state != IDLE);

  counter_with_strobe #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_counter (
    .clk         (clk),
    .rst         (cnt_rst),
    .enable      (cnt_enable),
    .reset_value (period_q),
    .ready       (cnt_ready),
    .strobe      (cnt_strobe)
  );
endmodule

// File: tb/tb_strobe_timer_arbiter.sv
// Scoreboard bench for strobe_timer_arbiter: expected grants and completions
// are queued when requests are issued and compared as the DUT produces them.
module tb_strobe_timer_arbiter;
  localparam int R = 4;
  localparam int W = 32;

  typedef struct {
    logic [R-1:0] done;
    logic         err;
  } done_t;

  logic clk = 1'b0;
  logic rst;

  strobe_timer_arbiter_if #(.REQUESTERS(R), .WIDTH(W)) bus ();

  strobe_timer_arbiter #(.REQUESTERS(R), .WIDTH(W), .LATENCY(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [R-1:0] exp_grant[$];
  done_t        exp_done[$];

  int           n_checks = 0;
  int           n_err    = 0;
  int           cyc      = 0;
  int           n_en, n_ovr, n_done;
  int           last_en_cyc, last_strobe_cyc, done_cyc, req_cyc;
  int           tick_every = 0;
  logic         auto_drop  = 1'b0;
  logic         cnt_rst_seen;
  logic [R-1:0] prev_grant = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_done(input logic [R-1:0] d, input logic e);
    done_t x;
    x.done = d;
    x.err  = e;
    exp_done.push_back(x);
  endtask

  task automatic set_period(input int i, input logic [W-1:0] p);
    bus.req_period[i*W +: W] = p;
  endtask

  // One clock: drive tick, sample mid-cycle, score any output events.
  task automatic cycle();
    done_t e;
    bus.tick = (tick_every != 0) && (cyc % tick_every == 0);
    #1;
    if (dut.cnt_enable) begin
      n_en++;
      last_en_cyc = cyc;
      check("enable_needs_ready", dut.cnt_ready, 1'b1);
    end
    if (bus.tick_overrun) n_ovr++;
    if (dut.cnt_strobe) last_strobe_cyc = cyc;
    cnt_rst_seen = dut.cnt_rst;
    if (bus.grant != prev_grant && bus.grant != '0) begin
      check("grant_onehot", $onehot(bus.grant), 1'b1);
      if (exp_grant.size() == 0) check("grant_unexpected", bus.grant, '0);
      else check("grant", bus.grant, exp_grant.pop_front());
    end
    prev_grant = bus.grant;
    if (bus.done != '0 || bus.error) begin
      if (exp_done.size() == 0) begin
        check("done_unexpected", {bus.error, bus.done}, '0);
      end else begin
        e = exp_done.pop_front();
        check("done", bus.done, e.done);
        check("error", bus.error, e.err);
      end
      done_cyc = cyc;
      n_done++;
      if (auto_drop) bus.req = bus.req & ~bus.done;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_dones(input int n, input int budget);
    int target;
    int k;
    target = n_done + n;
    k = 0;
    while (n_done < target && k < budget) begin
      cycle();
      k++;
    end
    if (n_done < target) check("timeout_done", n_done, target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    tick_every = 0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    bus.tick = 1'b0;
    bus.req = '0;
    bus.req_period = '0;
    n_en = 0; n_ovr = 0; n_done = 0;
    last_en_cyc = -1; last_strobe_cyc = -1; done_cyc = -1; req_cyc = 0;
    @(negedge clk);

    // Reset state.
    rst = 1'b1;
    cycle();
    cycle();
    check("rst_grant", bus.grant, '0);
    check("rst_done", bus.done, '0);
    check("rst_error", bus.error, 1'b0);
    check("rst_overrun", bus.tick_overrun, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ptr", dut.ptr, '0);
    check("rst_cnt_ready", dut.cnt_ready, 1'b0);
    rst = 1'b0;
    cycle();

    // Single request, period 5, tick every cycle: ready drops for 2 cycles
    // after each enable, so 1 + 2+2+2 + 1 (strobe cycle) ticks overrun.
    set_period(1, 5);
    tick_every = 1; auto_drop = 1'b1;
    n_en = 0; n_ovr = 0;
    exp_grant.push_back(4'b0010);
    expect_done(4'b0010, 1'b0);
    bus.req = 4'b0010;
    cycle();
    check("a_grant_latency", bus.grant, 4'b0010);
    wait_dones(1, 100);
    check("a_enables", n_en, 5);
    check("a_overruns", n_ovr, 8);
    check("a_strobe_after_en", last_strobe_cyc - last_en_cyc, 1);
    check("a_done_after_strobe", done_cyc - last_strobe_cyc, 1);
    check("a_grant_cleared", bus.grant, '0);
    tick_every = 0;
    repeat (3) cycle();

    // Fairness: all four requesting, period 3.
    do_reset();
    for (int i = 0; i < R; i++) set_period(i, 3);
    auto_drop = 1'b0;
    tick_every = 1;
    for (int i = 0; i < 5; i++) begin
      exp_grant.push_back(4'b0001 << (i % R));
      expect_done(4'b0001 << (i % R), 1'b0);
    end
    bus.req = 4'b1111;
    wait_dones(5, 300);
    bus.req = '0;
    tick_every = 0;
    repeat (3) cycle();
    check("f_grant_q_empty", exp_grant.size(), 0);
    check("f_done_q_empty", exp_done.size(), 0);

    // Reject: period 1 on client 2.
    set_period(2, 1);
    auto_drop = 1'b1;
    n_en = 0;
    exp_grant.push_back(4'b0100);
    expect_done(4'b0100, 1'b1);
    bus.req = 4'b0100;
    req_cyc = cyc;
    wait_dones(1, 20);
    check("r_latency", done_cyc - req_cyc, 2);
    check("r_no_enable", n_en, 0);
    repeat (3) cycle();
    check("r_idle", bus.busy, 1'b0);

    // Abort: client 3 period 10 dropped after 4 enables; client 0 follows.
    set_period(3, 10);
    set_period(0, 3);
    tick_every = 1;
    n_en = 0;
    exp_grant.push_back(4'b1000);
    bus.req = 4'b1000;
    cycle();
    bus.req = 4'b1001;
    begin
      int k;
      k = 0;
      while (n_en < 4 && k < 100) begin
        cycle();
        k++;
      end
      if (n_en < 4) check("timeout_abort_en", n_en, 4);
    end
    bus.req = 4'b0001;
    cycle();
    check("ab_cnt_rst", cnt_rst_seen, 1'b1);
    check("ab_grant_clr", bus.grant, '0);
    check("ab_no_done", bus.done, '0);
    exp_grant.push_back(4'b0001);
    expect_done(4'b0001, 1'b0);
    n_en = 0;
    wait_dones(1, 100);
    check("ab_restart_en", n_en, 3);
    tick_every = 0;
    repeat (3) cycle();

    // Sparse ticks: period 4, one tick every 8 cycles.
    set_period(1, 4);
    tick_every = 8;
    n_en = 0; n_ovr = 0;
    exp_grant.push_back(4'b0010);
    expect_done(4'b0010, 1'b0);
    bus.req = 4'b0010;
    wait_dones(1, 200);
    check("s_enables", n_en, 4);
    check("s_overruns", n_ovr, 0);
    check("s_strobe_after_en", last_strobe_cyc - last_en_cyc, 1);
    check("s_done_after_strobe", done_cyc - last_strobe_cyc, 1);
    tick_every = 0;
    repeat (3) cycle();

    // Reset in the middle of a count.
    set_period(2, 20);
    tick_every = 1;
    auto_drop = 1'b0;
    exp_grant.push_back(4'b0100);
    bus.req = 4'b0100;
    repeat (12) cycle();
    check("m_busy_before", bus.busy, 1'b1);
    rst = 1'b1;
    bus.req = 4'b1111;
    cycle();
    rst = 1'b0;
    check("m_grant", bus.grant, '0);
    check("m_done", bus.done, '0);
    check("m_error", bus.error, 1'b0);
    check("m_overrun", bus.tick_overrun, 1'b0);
    check("m_busy", bus.busy, 1'b0);
    check("m_ptr", dut.ptr, '0);
    exp_grant.push_back(4'b0001);
    cycle();
    check("m_first_grant", bus.grant, 4'b0001);
    bus.req = '0;
    tick_every = 0;
    repeat (4) cycle();
    check("end_grant_q_empty", exp_grant.size(), 0);
    check("end_done_q_empty", exp_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
